// File: rtl/code_detector.sv
// code_detector
//   Receive-side phase-code detector. While `sinc` is high it samples the
//   received chip stream `in` at mid-chip, rebuilds the code word LSB first,
//   compares it with the expected code and emits a one-cycle result strobe.
//
//   Optional feature macro: CODE_DETECTOR_CORR_EN
//     defined   -> `corr` = N - 2*errors, registered with `valid`
//     undefined -> `corr` is tied to 0
//
// Parameters
//   LAT     : edges from acquisition start until chip 0 is visible on `in`
//   MAX_ERR : largest error count still reported as a match
//
// Ports
//   clk      : clock, rising edge
//   rst      : synchronous active-low reset
//   sinc     : acquisition window (high arms, low aborts / re-enables)
//   num_dig  : code length in bits (clamped to 32)
//   codigo   : expected code, bit k = chip k
//   tiempo_b : chip width in clock cycles (0 treated as 1)
//   in       : received chip stream
//   busy     : acquisition in progress
//   valid    : one-cycle result strobe
//   match    : errors <= MAX_ERR (held)
//   errors   : Hamming distance over the used bits (held)
//   rx_code  : recovered word, unused upper bits 0 (held)
//   corr     : signed correlation score (held)
module code_detector #(
  parameter int unsigned LAT     = 1,
  parameter int unsigned MAX_ERR = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sinc,
  input  logic [31:0]        num_dig,
  input  logic [31:0]        codigo,
  input  logic [31:0]        tiempo_b,
  input  logic               in,
  output logic               busy,
  output logic               valid,
  output logic               match,
  output logic [5:0]         errors,
  output logic [31:0]        rx_code,
  output logic signed [6:0]  corr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_ACQ,
    S_CMP,
    S_HOLD
  } state_t;

  state_t      state_q, state_d;

  // Latched configuration
  logic [5:0]  n_q;
  logic [31:0] t_q;
  logic [31:0] code_q;

  // Acquisition datapath
  logic [31:0] rx_q;
  logic [5:0]  bit_q;
  logic [31:0] cnt_q;

  // Effective configuration seen at the start edge
  logic [5:0]  n_in;
  logic [31:0] t_in;
  logic [31:0] d_in;

  logic        do_start;
  logic        do_sample;
  logic        do_cmp;

  logic [31:0] rx_base;
  logic [5:0]  bit_base;
  logic [31:0] t_eff;

  logic [31:0] mask;
  logic [31:0] diff;
  logic [5:0]  err_cnt;

  assign n_in = (num_dig > 32'd32) ? 6'd32 : num_dig[5:0];
  assign t_in = (tiempo_b == '0) ? 32'd1 : tiempo_b;
  // Edges from the start edge to the first sample: LAT plus half a chip.
  assign d_in = 32'(LAT) + (t_in >> 1);

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and control strobes.
  // cnt_q holds the edges remaining before the next sample; ALIGN hands over
  // to ACQ one edge early so the first ACQ edge with cnt_q == 0 is the sample.
  always_comb begin
    state_d   = state_q;
    do_start  = 1'b0;
    do_sample = 1'b0;
    do_cmp    = 1'b0;
    busy      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (sinc) begin
          if (n_in == '0) begin
            state_d = S_HOLD;
          end else begin
            do_start = 1'b1;
            if (d_in == '0) begin
              // No alignment delay: chip 0 is sampled on the start edge.
              do_sample = 1'b1;
              state_d   = (n_in == 6'd1) ? S_CMP : S_ACQ;
            end else if (d_in == 32'd1) begin
              state_d = S_ACQ;
            end else begin
              state_d = S_ALIGN;
            end
          end
        end
      end

      S_ALIGN: begin
        busy = 1'b1;
        if (!sinc) begin
          state_d = S_IDLE;
        end else if (cnt_q == 32'd1) begin
          state_d = S_ACQ;
        end
      end

      S_ACQ: begin
        busy = 1'b1;
        if (!sinc) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          do_sample = 1'b1;
          if (bit_q == n_q - 6'd1) begin
            state_d = S_CMP;
          end
        end
      end

      S_CMP: begin
        busy    = 1'b1;
        do_cmp  = 1'b1;
        state_d = S_HOLD;
      end

      S_HOLD: begin
        if (!sinc) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // A sample on the start edge must see the freshly cleared register state.
  assign rx_base  = do_start ? '0 : rx_q;
  assign bit_base = do_start ? '0 : bit_q;
  assign t_eff    = do_start ? t_in : t_q;

  // Used-bit mask and error count
  always_comb begin
    mask    = '0;
    err_cnt = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      mask[i] = (i < 32'(n_q));
    end
    diff = (rx_q ^ code_q) & mask;
    for (int unsigned i = 0; i < 32; i++) begin
      err_cnt = err_cnt + 6'(diff[i]);
    end
  end

  // Datapath and held result registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      n_q     <= '0;
      t_q     <= '0;
      code_q  <= '0;
      rx_q    <= '0;
      bit_q   <= '0;
      cnt_q   <= '0;
      valid   <= 1'b0;
      match   <= 1'b0;
      errors  <= '0;
      rx_code <= '0;
    end else begin
      valid <= do_cmp;

      if (do_start) begin
        n_q    <= n_in;
        t_q    <= t_in;
        code_q <= codigo;
      end

      if (do_sample) begin
        rx_q  <= rx_base | (32'(in) << bit_base);
        bit_q <= bit_base + 6'd1;
        cnt_q <= t_eff - 32'd1;
      end else if (do_start) begin
        rx_q  <= '0;
        bit_q <= '0;
        cnt_q <= d_in - 32'd1;
      end else if (state_q == S_ALIGN || state_q == S_ACQ) begin
        cnt_q <= cnt_q - 32'd1;
      end

      if (do_cmp) begin
        rx_code <= rx_q & mask;
        errors  <= err_cnt;
        match   <= (32'(err_cnt) <= MAX_ERR);
      end
    end
  end

`ifdef CODE_DETECTOR_CORR_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      corr <= '0;
    end else if (do_cmp) begin
      corr <= $signed({1'b0, n_q}) - $signed({err_cnt, 1'b0});
    end
  end
`else
  assign corr = '0;
`endif

endmodule

// File: tb/tb_code_detector.sv
// Testbench for code_detector: a generator model drives the chip stream,
// expected results go into a scoreboard queue when an acquisition starts and
// are compared when `valid` strobes. A second instance with MAX_ERR=1 shares
// the stimulus so both match thresholds are covered.
module tb_code_detector;

  localparam int unsigned LAT = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sinc = 1'b0;
  logic        in = 1'b0;
  logic [31:0] num_dig = '0;
  logic [31:0] codigo = '0;
  logic [31:0] tiempo_b = '0;

  logic        busy, valid, match;
  logic [5:0]  errors;
  logic [31:0] rx_code;
  logic signed [6:0] corr;

  logic        busy1, valid1, match1;
  logic [5:0]  errors1;
  logic [31:0] rx_code1;
  logic signed [6:0] corr1;

  code_detector #(.LAT(LAT), .MAX_ERR(0)) dut (
    .clk(clk), .rst(rst), .sinc(sinc), .num_dig(num_dig), .codigo(codigo),
    .tiempo_b(tiempo_b), .in(in), .busy(busy), .valid(valid), .match(match),
    .errors(errors), .rx_code(rx_code), .corr(corr)
  );

  code_detector #(.LAT(LAT), .MAX_ERR(1)) dut1 (
    .clk(clk), .rst(rst), .sinc(sinc), .num_dig(num_dig), .codigo(codigo),
    .tiempo_b(tiempo_b), .in(in), .busy(busy1), .valid(valid1), .match(match1),
    .errors(errors1), .rx_code(rx_code1), .corr(corr1)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rx;
    logic [5:0]  err;
    logic        m0;
    logic        m1;
    logic [6:0]  corr;
    int unsigned cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  logic [31:0] last_rx = '0;
  logic [5:0]  last_err = '0;
  logic        last_m = 1'b0;
  logic [6:0]  last_corr = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Result monitor
  logic valid_q = 1'b0;
  always @(negedge clk) begin
    if (rst && valid) begin
      chk("valid_one_cycle", 32'(valid_q), 32'd0);
      if (sb.size() == 0) begin
        chk("valid_expected", 32'(sb.size()), 32'd1);
      end else begin
        mon_e = sb.pop_front();
        chk("rx_code", rx_code, mon_e.rx);
        chk("errors", 32'(errors), 32'(mon_e.err));
        chk("match", 32'(match), 32'(mon_e.m0));
        chk("match_maxerr1", 32'(match1), 32'(mon_e.m1));
        chk("corr", 32'(unsigned'(corr)), 32'(mon_e.corr));
        chk("valid_edge", cyc, mon_e.cyc);
        chk("busy_at_valid", 32'(busy), 32'd0);
      end
    end
    valid_q = valid;
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_valid"}, 32'(valid), 32'd0);
    chk({tag, "_match"}, 32'(match), 32'd0);
    chk({tag, "_errors"}, 32'(errors), 32'd0);
    chk({tag, "_rx_code"}, rx_code, 32'd0);
    chk({tag, "_corr"}, 32'(unsigned'(corr)), 32'd0);
  endtask

  // One acquisition window driven by a generator model.
  // corrupt: chip index inverted over its whole window (-1 none)
  // abort_at / rst_at: j of edge e0+j where sinc drops / rst asserts (-1 none)
  task automatic acquire(input logic [31:0] nd, input logic [31:0] cd,
                         input logic [31:0] tb, input int corrupt,
                         input int abort_at, input int rst_at);
    int unsigned n, t, h, e0, last, chip;
    int          err;
    logic [31:0] mask, rx;
    exp_t        e;

    n = (nd > 32) ? 32 : nd;
    t = (tb == 0) ? 1 : tb;
    h = t / 2;

    num_dig  = nd;
    codigo   = cd;
    tiempo_b = tb;
    sinc     = 1'b1;
    in       = 1'b0;
    e0   = cyc + 1;
    last = e0 + LAT + (n - 1) * t + h + 1;

    if (abort_at < 0 && rst_at < 0) begin
      mask = (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
      rx   = cd & mask;
      err  = 0;
      if (corrupt >= 0 && corrupt < int'(n)) begin
        rx[corrupt] = ~rx[corrupt];
        err = 1;
      end
      e.rx  = rx;
      e.err = 6'(err);
      e.m0  = (err <= 0);
      e.m1  = (err <= 1);
`ifdef CODE_DETECTOR_CORR_EN
      e.corr = 7'(int'(n) - 2 * err);
`else
      e.corr = '0;
`endif
      e.cyc = last;
      sb.push_back(e);
      last_rx = e.rx; last_err = e.err; last_m = e.m0; last_corr = e.corr;
    end

    for (int j = 1; j <= int'(last - e0) + 3; j++) begin
      @(negedge clk);
      if (j == 1) chk("busy_after_start", 32'(busy), 32'd1);
      chip = (j - 1) / t;
      in = (chip < n) ? (cd[chip] ^ (int'(chip) == corrupt)) : 1'b0;
      if (j == abort_at) sinc = 1'b0;
      if (j == rst_at) begin
        rst = 1'b0;
        @(negedge clk);
        chk_zero("rst_mid");
        last_rx = '0; last_err = '0; last_m = 1'b0; last_corr = '0;
        rst = 1'b1;
        return;
      end
    end

    if (abort_at >= 0) begin
      chk("abort_held_rx", rx_code, last_rx);
      chk("abort_held_err", 32'(errors), 32'(last_err));
      chk("abort_held_match", 32'(match), 32'(last_m));
      chk("abort_held_corr", 32'(unsigned'(corr)), 32'(last_corr));
    end
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    sinc = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  logic saw_busy;

  initial begin
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b1;

    // Zero-length code: no acquisition, no result
    num_dig  = '0;
    codigo   = 32'h5;
    tiempo_b = 32'd2;
    sinc     = 1'b1;
    saw_busy = 1'b0;
    repeat (8) begin
      @(negedge clk);
      saw_busy = saw_busy | busy;
    end
    chk("n0_busy", 32'(saw_busy), 32'd0);
    sinc = 1'b0;
    repeat (2) @(negedge clk);

    acquire(32'd4, 32'hD, 32'd4, -1, -1, -1);          // clean
    acquire(32'd4, 32'hD, 32'd4, 2, -1, -1);           // chip 2 corrupted
    acquire(32'd4, 32'hD, 32'd4, -1, 6, -1);           // abort at e0+6
    acquire(32'd4, 32'hD, 32'd4, -1, -1, -1);          // decode after abort
    acquire(32'd40, 32'hA5A5_F00F, 32'd0, -1, -1, -1); // N and T clamps
    acquire(32'd4, 32'h6, 32'd3, 0, -1, -1);           // odd chip width
    acquire(32'd1, 32'hFFFF_FFFE, 32'd2, -1, -1, -1);  // single bit, upper bits masked
    acquire(32'd4, 32'hD, 32'd4, -1, -1, 8);           // reset mid-acquisition
    acquire(32'd4, 32'hD, 32'd4, 3, -1, -1);           // restarts with sinc still high

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
